traffic_light_timed: RTL and testbench

- Two-road (NS/EW) traffic light controller that replaces the fixed one-state-per-clock sequencer.
- Each phase lasts a parametrised number of cycles, and an all-red clearance phase follows each yellow.
- Demand-actuated: a green holds until the cross road has a latched request.
- An emergency flashing-yellow override is provided.
- Sits between the intersection sensor/override inputs and the lamp drivers.

---
 rtl/traffic_light_timed.sv | 189 ++++++++++++++++++
 tb/tb_traffic_light_timed.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_timed.sv
// Two-road timed traffic light controller with demand latching,
// all-red clearance and an emergency flashing-yellow override.
module traffic_light_timed #(
    parameter int GREEN_MIN     = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 1,
    parameter int FLASH_HALF    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ns_req,
    input  logic             ew_req,
    input  logic             flash_mode,
    output logic             NS_G,
    output logic             NS_Y,
    output logic             NS_R,
    output logic             EW_G,
    output logic             EW_Y,
    output logic             EW_R,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] timer_o
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        AR_TO_EW  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        AR_TO_NS  = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic             ns_pend;
    logic             ns_pend_n;
    logic             ew_pend;
    logic             ew_pend_n;
    logic             flash_phase;
    logic             flash_phase_n;
    logic             timer_done;

    assign timer_done = (timer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NS_GREEN;
            timer       <= GREEN_LD;
            ns_pend     <= 1'b0;
            ew_pend     <= 1'b0;
            flash_phase <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            ns_pend     <= ns_pend_n;
            ew_pend     <= ew_pend_n;
            flash_phase <= flash_phase_n;
        end
    end

    // Default is to stay put with the timer running down to zero.
    always_comb begin
        state_n       = state;
        timer_n       = timer_done ? timer : timer - 1'b1;
        flash_phase_n = flash_phase;
        if (flash_mode) begin
            if (state != FLASH) begin
                state_n       = FLASH;
                timer_n       = FLASH_LD;
                flash_phase_n = 1'b1;
            end else if (timer_done) begin
                timer_n       = FLASH_LD;
                flash_phase_n = ~flash_phase;
            end
        end else begin
            unique case (state)
                NS_GREEN: begin
                    if (timer_done && (ew_pend || ew_req)) begin
                        state_n = NS_YELLOW;
                        timer_n = YELLOW_LD;
                    end
                end
                NS_YELLOW: begin
                    if (timer_done) begin
                        state_n = AR_TO_EW;
                        timer_n = ALLRED_LD;
                    end
                end
                AR_TO_EW: begin
                    if (timer_done) begin
                        state_n = EW_GREEN;
                        timer_n = GREEN_LD;
                    end
                end
                EW_GREEN: begin
                    if (timer_done && (ns_pend || ns_req)) begin
                        state_n = EW_YELLOW;
                        timer_n = YELLOW_LD;
                    end
                end
                EW_YELLOW: begin
                    if (timer_done) begin
                        state_n = AR_TO_NS;
                        timer_n = ALLRED_LD;
                    end
                end
                AR_TO_NS: begin
                    if (timer_done) begin
                        state_n = NS_GREEN;
                        timer_n = GREEN_LD;
                    end
                end
                FLASH: begin
                    state_n       = AR_TO_NS;
                    timer_n       = ALLRED_LD;
                    flash_phase_n = 1'b0;
                end
                default: begin
                    state_n = AR_TO_NS;
                    timer_n = ALLRED_LD;
                end
            endcase
        end
    end

    // Requests latch outside FLASH; entering the served green clears them.
    always_comb begin
        ns_pend_n = ns_pend;
        ew_pend_n = ew_pend;
        if (state != FLASH) begin
            ns_pend_n = ns_pend | ns_req;
            ew_pend_n = ew_pend | ew_req;
            if (state_n == NS_GREEN && state != NS_GREEN) begin
                ns_pend_n = 1'b0;
            end
            if (state_n == EW_GREEN && state != EW_GREEN) begin
                ew_pend_n = 1'b0;
            end
        end
    end

    always_comb begin
        NS_G = 1'b0;
        NS_Y = 1'b0;
        NS_R = 1'b0;
        EW_G = 1'b0;
        EW_Y = 1'b0;
        EW_R = 1'b0;
        unique case (state)
            NS_GREEN: begin
                NS_G = 1'b1;
                EW_R = 1'b1;
            end
            NS_YELLOW: begin
                NS_Y = 1'b1;
                EW_R = 1'b1;
            end
            EW_GREEN: begin
                EW_G = 1'b1;
                NS_R = 1'b1;
            end
            EW_YELLOW: begin
                EW_Y = 1'b1;
                NS_R = 1'b1;
            end
            FLASH: begin
                NS_Y = flash_phase;
                EW_Y = flash_phase;
            end
            default: begin
                NS_R = 1'b1;
                EW_R = 1'b1;
            end
        endcase
    end

    assign state_o = state;
    assign timer_o = timer;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed scoreboard checks of phase timing, demand latching, flash
// override and reset, followed by randomized lamp safety checks.
module tb_traffic_light_timed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic       NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R;
    logic [2:0] state_o;
    logic [7:0] timer_o;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [5:0] L_NSG = 6'b100_001;
    localparam logic [5:0] L_NSY = 6'b010_001;
    localparam logic [5:0] L_AR  = 6'b001_001;
    localparam logic [5:0] L_EWG = 6'b001_100;
    localparam logic [5:0] L_EWY = 6'b001_010;
    localparam logic [5:0] L_FL1 = 6'b010_010;
    localparam logic [5:0] L_FL0 = 6'b000_000;

    string       tag_q[$];
    logic [16:0] exp_q[$];

    logic [5:0] el;
    logic [2:0] es;
    int         et;

    traffic_light_timed #(
        .GREEN_MIN(4),
        .YELLOW_CYCLES(2),
        .ALLRED_CYCLES(1),
        .FLASH_HALF(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ns_req(ns_req),
        .ew_req(ew_req),
        .flash_mode(flash_mode),
        .NS_G(NS_G),
        .NS_Y(NS_Y),
        .NS_R(NS_R),
        .EW_G(EW_G),
        .EW_Y(EW_Y),
        .EW_R(EW_R),
        .state_o(state_o),
        .timer_o(timer_o)
    );

    always #5 clk = ~clk;

    // Expected view of the free-running cycle under constant demand.
    function automatic void norm(input int p, output logic [5:0] l,
                                 output logic [2:0] s, output int t);
        if (p < 4) begin
            l = L_NSG; s = 3'd0; t = 3 - p;
        end else if (p < 6) begin
            l = L_NSY; s = 3'd1; t = 5 - p;
        end else if (p == 6) begin
            l = L_AR; s = 3'd2; t = 0;
        end else if (p < 11) begin
            l = L_EWG; s = 3'd3; t = 10 - p;
        end else if (p < 13) begin
            l = L_EWY; s = 3'd4; t = 12 - p;
        end else begin
            l = L_AR; s = 3'd5; t = 0;
        end
    endfunction

    task automatic push(input string tag, input logic [5:0] l,
                        input logic [2:0] s, input int t);
        tag_q.push_back(tag);
        exp_q.push_back({l, s, 8'(t)});
    endtask

    task automatic pop_check();
        logic [16:0] obs;
        logic [16:0] exp;
        string       tag;
        obs = {NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R, state_o, timer_o};
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %b required an expected entry", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed lamps=%b st=%0d tm=%0d required lamps=%b st=%0d tm=%0d",
                       tag, obs[16:11], obs[10:8], obs[7:0],
                       exp[16:11], exp[10:8], exp[7:0]);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [5:0] l,
                              input logic [2:0] s, input int t);
        push(tag, l, s, t);
        pop_check();
    endtask

    task automatic expect_next(input string tag, input logic [5:0] l,
                               input logic [2:0] s, input int t);
        push(tag, l, s, t);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        ns_req     = 1'b0;
        ew_req     = 1'b0;
        flash_mode = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_safety();
        logic ok;
        n_assert++;
        ok = !(NS_G && EW_G);
        if (state_o == 3'd6) begin
            ok = ok && !NS_G && !EW_G && !NS_R && !EW_R && (NS_Y == EW_Y);
        end else begin
            ok = ok && $onehot({NS_G, NS_Y, NS_R}) && $onehot({EW_G, EW_Y, EW_R});
            ok = ok && (!(NS_G || NS_Y) || EW_R) && (!(EW_G || EW_Y) || NS_R);
        end
        assert (ok) else begin
            n_fail++;
            $error("FAIL safety: observed lamps=%b st=%0d required a safe lamp set",
                   {NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R}, state_o);
        end
        n_assert++;
        assert (state_o !== 3'd7) else begin
            n_fail++;
            $error("FAIL illegal_state: observed %0d required not 7", state_o);
        end
    endtask

    initial begin
        // Constant demand on both roads: 14-cycle period.
        reset_dut();
        expect_now("s1_reset", L_NSG, 3'd0, 3);
        check_safety();
        ns_req = 1'b1;
        ew_req = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            norm(c % 14, el, es, et);
            expect_next($sformatf("s1_cyc%0d", c), el, es, et);
        end

        // No cross demand: NS green holds with timer at zero.
        reset_dut();
        for (int c = 1; c <= 30; c++) begin
            expect_next($sformatf("s2_hold%0d", c), L_NSG, 3'd0, (c < 3) ? 3 - c : 0);
        end
        ew_req = 1'b1;
        expect_next("s2_nsy31", L_NSY, 3'd1, 1);
        ew_req = 1'b0;
        expect_next("s2_nsy32", L_NSY, 3'd1, 0);
        expect_next("s2_ar33", L_AR, 3'd2, 0);
        for (int c = 34; c <= 40; c++) begin
            expect_next($sformatf("s2_ewg%0d", c), L_EWG, 3'd3, (c < 37) ? 37 - c : 0);
        end

        // Single-cycle pulses latched during minimum green.
        reset_dut();
        for (int c = 1; c <= 20; c++) begin
            ew_req = (c - 1 == 1);
            ns_req = (c - 1 == 8);
            if (c <= 17) begin
                norm(c % 14, el, es, et);
            end else begin
                el = L_NSG; es = 3'd0; et = 0;
            end
            expect_next($sformatf("s3_cyc%0d", c), el, es, et);
        end
        ns_req = 1'b0;
        ew_req = 1'b0;

        // Flash override entered from EW green.
        reset_dut();
        ew_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            norm(c, el, es, et);
            expect_next($sformatf("s4_cyc%0d", c), el, es, et);
            ew_req = 1'b0;
        end
        flash_mode = 1'b1;
        for (int c = 9; c <= 14; c++) begin
            el = (((c - 9) / 2) % 2 == 0) ? L_FL1 : L_FL0;
            expect_next($sformatf("s4_flash%0d", c), el, 3'd6, 1 - ((c - 9) % 2));
        end
        flash_mode = 1'b0;
        expect_next("s4_ar15", L_AR, 3'd5, 0);
        for (int c = 16; c <= 21; c++) begin
            expect_next($sformatf("s4_nsg%0d", c), L_NSG, 3'd0, (c < 19) ? 19 - c : 0);
        end

        // Reset mid EW yellow clears state and pending requests.
        reset_dut();
        ns_req = 1'b1;
        ew_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            norm(c, el, es, et);
            expect_next($sformatf("s5_cyc%0d", c), el, es, et);
        end
        rst = 1'b1;
        expect_next("s5_rst", L_NSG, 3'd0, 3);
        rst    = 1'b0;
        ns_req = 1'b0;
        ew_req = 1'b0;
        for (int c = 13; c <= 20; c++) begin
            expect_next($sformatf("s5_nsg%0d", c), L_NSG, 3'd0, (c < 15) ? 15 - c : 0);
        end

        // Random stimulus: lamp safety every cycle.
        reset_dut();
        for (int i = 0; i < 10000; i++) begin
            ns_req = ($urandom_range(0, 3) == 0);
            ew_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) flash_mode = ~flash_mode;
            rst = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
            check_safety();
        end

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
